// File: rtl/deser_pkg.sv
// Shared constants and helpers for the serial deserializer.
package deser_pkg;

    // Bit-order encoding held in the per-frame order latch
    localparam logic ORD_MSB = 1'b0;
    localparam logic ORD_LSB = 1'b1;

    // Word widths the deserializer supports
    function automatic bit deser_width_ok(input int w);
        return (w >= 2) && (w <= 32);
    endfunction

endpackage

// File: rtl/deser_out_buf.sv
// One-word valid/ready holding register. A word that arrives while the
// register is full and not being drained is dropped and flagged on drop.
module deser_out_buf #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             q_vld,
    input  logic             q_rdy,
    output logic             drop
);

    logic take;

    // The register can take a new word when it is empty or being drained this edge
    assign take = !q_vld || q_rdy;
    assign drop = load && !take;

    // Load on free slot (back-to-back allowed); otherwise clear valid on acceptance
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q     <= '0;
            q_vld <= 1'b0;
        end else if (load && take) begin
            q     <= din;
            q_vld <= 1'b1;
        end else if (q_vld && q_rdy) begin
            q_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_deserializer.sv
// Serial-in/parallel-out receiver. Collects WIDTH bits per frame, in the
// bit order sampled with the frame's first bit, and hands each word to a
// one-word valid/ready output buffer. The frame state is encoded by bit_cnt.
module serial_deserializer
    import deser_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             din,
    input  logic             din_vld,
    input  logic             lsb_first,
    input  logic             flush,
    output logic [WIDTH-1:0] q,
    output logic             q_vld,
    input  logic             q_rdy,
    output logic             busy,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             ovf
);

    if (!deser_width_ok(WIDTH)) begin : g_bad_width
        $error("serial_deserializer: WIDTH must be in 2..32");
    end

    logic [WIDTH-1:0] sh_reg;
    logic [WIDTH-1:0] sh_next;
    logic             ord;
    logic             ord_eff;
    logic             first_bit;
    logic             last_bit;
    logic             word_load;
    logic             drop;

    // The first bit of a frame uses the live lsb_first; later bits use the latch
    assign first_bit = (bit_cnt == '0);
    assign last_bit  = (bit_cnt == CNT_W'(WIDTH - 1));
    assign ord_eff   = first_bit ? lsb_first : ord;
    assign word_load = din_vld && !flush && last_bit;
    assign busy      = !first_bit;

    // Next shift-register value including the bit on din, so the completed word can be handed off on the same edge
    always_comb begin
        sh_next = sh_reg;
        if (ord_eff == ORD_LSB) sh_next = {din, sh_reg[WIDTH-1:1]};
        else                    sh_next = {sh_reg[WIDTH-2:0], din};
    end

    // Shift register, bit counter and order latch; flush wins over din_vld
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sh_reg  <= '0;
            bit_cnt <= '0;
            ord     <= ORD_MSB;
        end else if (flush) begin
            sh_reg  <= '0;
            bit_cnt <= '0;
        end else if (din_vld) begin
            sh_reg  <= sh_next;
            bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
            if (first_bit) ord <= lsb_first;
        end
    end

    // Sticky overflow: set when a completed word is dropped, cleared only by flush
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)       ovf <= 1'b0;
        else if (flush) ovf <= 1'b0;
        else if (drop)  ovf <= 1'b1;
    end

    deser_out_buf #(.WIDTH(WIDTH)) u_out_buf (
        .clk   (clk),
        .clr   (clr),
        .load  (word_load),
        .din   (sh_next),
        .q     (q),
        .q_vld (q_vld),
        .q_rdy (q_rdy),
        .drop  (drop)
    );

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer (WIDTH=4) with a bit-queue reference model.
module tb_serial_deserializer;

    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          clr;
    logic          din;
    logic          din_vld;
    logic          lsb_first;
    logic          flush;
    logic          q_rdy;
    logic [W-1:0]  q;
    logic          q_vld;
    logic          busy;
    logic [CW-1:0] bit_cnt;
    logic          ovf;

    serial_deserializer #(.WIDTH(W)) dut (
        .clk       (clk),
        .clr       (clr),
        .din       (din),
        .din_vld   (din_vld),
        .lsb_first (lsb_first),
        .flush     (flush),
        .q         (q),
        .q_vld     (q_vld),
        .q_rdy     (q_rdy),
        .busy      (busy),
        .bit_cnt   (bit_cnt),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: the frame as a list of received bits
    bit           m_bits[$];
    logic         m_ord;
    logic [W-1:0] m_q;
    logic         m_qv;
    logic         m_ovf;
    logic [W-1:0] acc_log[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_ord = 1'b0;
        m_q   = '0;
        m_qv  = 1'b0;
        m_ovf = 1'b0;
    endtask

    // Bit i of the frame lands at position i (LSB-first) or W-1-i (MSB-first)
    function automatic logic [W-1:0] assemble();
        logic [W-1:0] w = '0;
        for (int i = 0; i < W; i++) begin
            if (m_ord) w[i] = m_bits[i];
            else       w[W-1-i] = m_bits[i];
        end
        return w;
    endfunction

    task automatic model_edge();
        logic accept;
        logic [W-1:0] word;
        accept = m_qv && q_rdy;
        if (flush) begin
            m_bits.delete();
            m_ovf = 1'b0;
            if (accept) m_qv = 1'b0;
        end else if (din_vld) begin
            if (m_bits.size() == 0) m_ord = lsb_first;
            m_bits.push_back(din);
            if (m_bits.size() == W) begin
                word = assemble();
                m_bits.delete();
                if (!m_qv || q_rdy) begin
                    m_q  = word;
                    m_qv = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (accept) begin
                m_qv = 1'b0;
            end
        end else if (accept) begin
            m_qv = 1'b0;
        end
    endtask

    task automatic compare_all();
        chk("q",       32'(q),       32'(m_q));
        chk("q_vld",   32'(q_vld),   32'(m_qv));
        chk("ovf",     32'(ovf),     32'(m_ovf));
        chk("bit_cnt", 32'(bit_cnt), 32'(m_bits.size()));
        chk("busy",    32'(busy),    32'(m_bits.size() != 0));
    endtask

    // One clock: log any handshake, let the edge happen, step the model, check
    task automatic tick();
        if (q_vld && q_rdy) acc_log.push_back(q);
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic cyc(input logic d, input logic v);
        din     = d;
        din_vld = v;
        tick();
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic lsb);
        lsb_first = lsb;
        for (int i = 0; i < W; i++) cyc(lsb ? w[i] : w[W-1-i], 1'b1);
        din_vld = 1'b0;
    endtask

    initial begin
        clr = 1'b0; din = 1'b0; din_vld = 1'b0; lsb_first = 1'b0;
        flush = 1'b0; q_rdy = 1'b1;
        model_reset();
        #3;
        chk("rst_q",     32'(q),       32'h0);
        chk("rst_q_vld", 32'(q_vld),   32'h0);
        chk("rst_cnt",   32'(bit_cnt), 32'h0);
        chk("rst_ovf",   32'(ovf),     32'h0);
        @(negedge clk);
        clr = 1'b1;
        cyc(1'b0, 1'b0);

        // 1: MSB-first 1,1,0,0
        send_word(4'b1100, 1'b0);
        chk("t1_q", 32'(q), 32'hC);
        chk("t1_vld", 32'(q_vld), 32'h1);
        chk("t1_busy", 32'(busy), 32'h0);
        cyc(1'b0, 1'b0);

        // 2: LSB-first 1,1,0,0, lsb_first toggled after bit 1
        lsb_first = 1'b1;
        cyc(1'b1, 1'b1);
        lsb_first = 1'b0;
        cyc(1'b1, 1'b1);
        lsb_first = 1'b1;
        cyc(1'b0, 1'b1);
        lsb_first = 1'b0;
        cyc(1'b0, 1'b1);
        chk("t2_q", 32'(q), 32'h3);
        din_vld = 1'b0;
        cyc(1'b0, 1'b0);

        // 3: three back-to-back words, consumer always ready
        acc_log.delete();
        send_word(4'b0110, 1'b0);
        send_word(4'b1001, 1'b0);
        send_word(4'b1111, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("t3_nacc", 32'(acc_log.size()), 32'd3);
        if (acc_log.size() == 3) begin
            chk("t3_w0", 32'(acc_log[0]), 32'h6);
            chk("t3_w1", 32'(acc_log[1]), 32'h9);
            chk("t3_w2", 32'(acc_log[2]), 32'hF);
        end

        // 4: overflow with consumer stalled
        q_rdy = 1'b0;
        send_word(4'b1010, 1'b0);
        send_word(4'b0101, 1'b0);
        chk("t4_q", 32'(q), 32'hA);
        chk("t4_ovf", 32'(ovf), 32'h1);
        q_rdy = 1'b1;
        cyc(1'b0, 1'b0);
        chk("t4_drain", 32'(q_vld), 32'h0);
        chk("t4_ovf_sticky", 32'(ovf), 32'h1);
        flush = 1'b1;
        cyc(1'b0, 1'b0);
        flush = 1'b0;
        chk("t4_flush_ovf", 32'(ovf), 32'h0);

        // 5: partial frame discarded by flush
        lsb_first = 1'b0;
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        chk("t5_cnt2", 32'(bit_cnt), 32'd2);
        flush = 1'b1;
        cyc(1'b1, 1'b1);
        flush = 1'b0;
        chk("t5_cnt0", 32'(bit_cnt), 32'd0);
        send_word(4'b0011, 1'b0);
        chk("t5_q", 32'(q), 32'h3);
        cyc(1'b0, 1'b0);

        // 6: async reset mid-frame with a pending word
        q_rdy = 1'b0;
        send_word(4'b1001, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        chk("t6_pre_vld", 32'(q_vld), 32'h1);
        chk("t6_pre_cnt", 32'(bit_cnt), 32'd3);
        #3;
        clr = 1'b0;
        #1;
        chk("t6_q", 32'(q), 32'h0);
        chk("t6_vld", 32'(q_vld), 32'h0);
        chk("t6_cnt", 32'(bit_cnt), 32'h0);
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_ovf", 32'(ovf), 32'h0);
        model_reset();
        din_vld = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        q_rdy = 1'b1;
        cyc(1'b0, 1'b0);
        send_word(4'b1101, 1'b1);
        chk("t6_post_q", 32'(q), 32'hD);
        cyc(1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
